// File: rtl/j1_sample_arbiter_if.sv
// Bus bundle for j1_sample_arbiter: CPU data port, ADC sample stream, data RAM and
// control-register access. The DUT uses the slave modport.
interface j1_sample_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 13
);
  logic [15:0]      cpu_addr;
  logic             cpu_wr;
  logic             cpu_rd;
  logic [WIDTH-1:0] cpu_dout;
  logic [WIDTH-1:0] cpu_din;

  logic             smp_valid;
  logic [WIDTH-1:0] smp_data;
  logic             smp_ready;

  logic [AW-1:0]    ram_addr;
  logic             ram_we;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  logic             io_wr;
  logic [2:0]       io_addr;
  logic [WIDTH-1:0] io_wdata;
  logic [WIDTH-1:0] io_rdata;

  modport slave (
    input  cpu_addr, cpu_wr, cpu_rd, cpu_dout, smp_valid, smp_data, ram_rdata,
    input  io_wr, io_addr, io_wdata,
    output cpu_din, smp_ready, ram_addr, ram_we, ram_wdata, io_rdata
  );

  modport master (
    output cpu_addr, cpu_wr, cpu_rd, cpu_dout, smp_valid, smp_data, ram_rdata,
    output io_wr, io_addr, io_wdata,
    input  cpu_din, smp_ready, ram_addr, ram_we, ram_wdata, io_rdata
  );
endinterface

// File: rtl/j1_sample_arbiter.sv
// Shares the j1 data RAM between the CPU (absolute priority) and a buffered ADC sample ring.
// Define J1_ARB_OVF_COUNT_EN to build the saturating 16-bit overflow counter (OVF register).
module j1_sample_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 13,
  parameter int unsigned BUF_LOG2 = 2
) (
  input logic                clk,
  input logic                reset,
  j1_sample_arbiter_if.slave bus
);
  localparam int unsigned Depth = 1 << BUF_LOG2;

  logic                en_q, en_d;
  logic [AW-1:0]       base_q, base_d, len_q, len_d, wptr_q, wptr_d;
  logic [BUF_LOG2:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [BUF_LOG2:0]   fill;
  logic [WIDTH-1:0]    fifo_mem [Depth];
  logic [WIDTH-1:0]    fifo_head;
  logic [AW:0]         wptr_inc;
  logic [15:0]         ovf_val;
  logic                cpu_acc, fifo_empty, fifo_full, push, drain;
  logic                ctrl_wr, base_wr, len_wr;

  assign cpu_acc    = bus.cpu_rd | bus.cpu_wr;
  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == (BUF_LOG2 + 1)'(Depth));
  assign fifo_head  = fifo_mem[rd_ptr_q[BUF_LOG2-1:0]];

  assign ctrl_wr = bus.io_wr && (bus.io_addr == 3'd0);
  assign base_wr = bus.io_wr && (bus.io_addr == 3'd1);
  assign len_wr  = bus.io_wr && (bus.io_addr == 3'd2);

  assign bus.smp_ready = !reset && en_q && (len_q != '0) && !fifo_full;
  assign push          = bus.smp_valid && bus.smp_ready;
  assign drain         = !reset && !cpu_acc && en_q && !fifo_empty;
  assign wptr_inc      = {1'b0, wptr_q} + (AW + 1)'(1);
  assign bus.cpu_din   = bus.ram_rdata;

  always_comb begin
    bus.ram_addr  = base_q + wptr_q;
    bus.ram_we    = drain;
    bus.ram_wdata = fifo_head;
    if (cpu_acc) begin
      bus.ram_addr  = bus.cpu_addr[AW-1:0];
      bus.ram_we    = bus.cpu_wr;
      bus.ram_wdata = bus.cpu_dout;
    end
  end

  always_comb begin
    en_d     = en_q;
    base_d   = base_q;
    len_d    = len_q;
    wptr_d   = wptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (drain) begin
      rd_ptr_d = rd_ptr_q + (BUF_LOG2 + 1)'(1);
      // ">=" rather than "==" so a LEN shrunk below WPTR wraps on the next drain
      wptr_d   = (wptr_inc >= {1'b0, len_q}) ? '0 : wptr_inc[AW-1:0];
    end
    if (push) wr_ptr_d = wr_ptr_q + (BUF_LOG2 + 1)'(1);
    if (ctrl_wr) begin
      en_d = bus.io_wdata[0];
      if (!bus.io_wdata[0]) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end else if (!en_q) begin
        wptr_d = '0;
      end
    end
    if (base_wr) base_d = bus.io_wdata[AW-1:0];
    if (len_wr)  len_d  = bus.io_wdata[AW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      wptr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      en_q     <= en_d;
      base_q   <= base_d;
      len_q    <= len_d;
      wptr_q   <= wptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[BUF_LOG2-1:0]] <= bus.smp_data;
  end

`ifdef J1_ARB_OVF_COUNT_EN
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ctrl_wr && bus.io_wdata[1]) begin
      ovf_d = '0;
    end else if (bus.smp_valid && en_q && !bus.smp_ready && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_val = ovf_q;
`else
  logic unused_clr;
  assign unused_clr = bus.io_wdata[1];
  assign ovf_val    = '0;
`endif

  always_comb begin
    bus.io_rdata = '0;
    if (!reset) begin
      case (bus.io_addr)
        3'd0:    bus.io_rdata = WIDTH'(en_q);
        3'd1:    bus.io_rdata = WIDTH'(base_q);
        3'd2:    bus.io_rdata = WIDTH'(len_q);
        3'd3:    bus.io_rdata = WIDTH'(wptr_q);
        3'd4:    bus.io_rdata = WIDTH'(ovf_val);
        default: bus.io_rdata = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.cpu_addr[15:AW], bus.io_wdata[WIDTH-1:AW]};
endmodule

// File: tb/tb_j1_sample_arbiter.sv
// Self-checking bench for j1_sample_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based model of the arbiter.
`timescale 1ns/1ps
module tb_j1_sample_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 13;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RAMSZ = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  j1_sample_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  j1_sample_arbiter #(.WIDTH(WIDTH), .AW(AW), .BUF_LOG2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data RAM behind the arbiter
  logic [WIDTH-1:0] ram [RAMSZ];
  assign bus.ram_rdata = ram[bus.ram_addr];
  always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_en   = 1'b0;
  int unsigned m_base = 0;
  int unsigned m_len  = 0;
  int unsigned m_wptr = 0;
  int unsigned m_ovf  = 0;
  logic [WIDTH-1:0] m_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !reset && m_en && (m_len != 0) && (m_q.size() < DEPTH);
  endfunction

  function automatic bit exp_drain();
    return !reset && !(bus.cpu_rd || bus.cpu_wr) && m_en && (m_q.size() > 0);
  endfunction

  function automatic logic [WIDTH-1:0] exp_io(input logic [2:0] a);
    if (reset) return '0;
    case (a)
      3'd0: return WIDTH'(m_en);
      3'd1: return WIDTH'(m_base);
      3'd2: return WIDTH'(m_len);
      3'd3: return WIDTH'(m_wptr);
`ifdef J1_ARB_OVF_COUNT_EN
      3'd4: return WIDTH'(m_ovf);
`endif
      default: return '0;
    endcase
  endfunction

  task automatic model_step();
    bit rdy, drn, pushed;
    if (reset) begin
      m_en = 0; m_base = 0; m_len = 0; m_wptr = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    rdy    = exp_ready();
    drn    = exp_drain();
    pushed = bus.smp_valid && rdy;
    if (bus.io_wr && bus.io_addr == 3'd0 && bus.io_wdata[1]) m_ovf = 0;
    else if (bus.smp_valid && m_en && !rdy && m_ovf < 65535) m_ovf++;
    if (drn) begin
      void'(m_q.pop_front());
      m_wptr = (m_wptr + 1 >= m_len) ? 0 : m_wptr + 1;
    end
    if (pushed) m_q.push_back(bus.smp_data);
    if (bus.io_wr) begin
      case (bus.io_addr)
        3'd0: begin
          if (!bus.io_wdata[0]) begin
            m_en = 0;
            m_q.delete();
          end else if (!m_en) begin
            m_en   = 1;
            m_wptr = 0;
          end
        end
        3'd1: m_base = bus.io_wdata % RAMSZ;
        3'd2: m_len  = bus.io_wdata % RAMSZ;
        default: ;
      endcase
    end
  endtask

  // One clock cycle: compare outputs at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit cpu_acc, drn;
    @(negedge clk);
    cpu_acc = bus.cpu_rd || bus.cpu_wr;
    drn     = exp_drain();
    check("smp_ready", bus.smp_ready, exp_ready());
    check("ram_we", bus.ram_we, cpu_acc ? bus.cpu_wr : drn);
    if (cpu_acc) check("ram_addr_cpu", bus.ram_addr, bus.cpu_addr % RAMSZ);
    else if (drn) check("ram_addr_ring", bus.ram_addr, (m_base + m_wptr) % RAMSZ);
    if (bus.cpu_wr) check("ram_wdata_cpu", bus.ram_wdata, bus.cpu_dout);
    else if (!cpu_acc && drn) check("ram_wdata_smp", bus.ram_wdata, m_q[0]);
    check("cpu_din", bus.cpu_din, bus.ram_rdata);
    check("io_rdata", bus.io_rdata, exp_io(bus.io_addr));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic io_write(input logic [2:0] a, input logic [WIDTH-1:0] d);
    bus.io_wr = 1'b1; bus.io_addr = a; bus.io_wdata = d;
    tick();
    bus.io_wr = 1'b0;
  endtask

  task automatic check_io(input string name, input logic [2:0] a, input logic [WIDTH-1:0] exp);
    bus.io_addr = a;
    #1;
    check(name, bus.io_rdata, exp);
  endtask

  initial begin
    int unsigned r, ovf_exp;
    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wr = 0; bus.cpu_rd = 0; bus.cpu_dout = '0;
    bus.smp_valid = 0; bus.smp_data = '0;
    bus.io_wr = 0; bus.io_addr = '0; bus.io_wdata = '0;
    repeat (3) tick();
    for (int a = 0; a < 5; a++) check_io("reset_io", 3'(a), '0);
    check("reset_ready", bus.smp_ready, 1'b0);
    reset = 1'b0;
    tick();

    // Ring of 4 at 0x100, six back-to-back samples
    io_write(3'd1, 32'h100);
    io_write(3'd2, 32'd4);
    io_write(3'd0, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      bus.smp_valid = 1; bus.smp_data = WIDTH'(i);
      tick();
    end
    bus.smp_valid = 0;
    repeat (3) tick();
    check("ring_0x100", ram[13'h100], 32'd5);
    check("ring_0x101", ram[13'h101], 32'd6);
    check("ring_0x102", ram[13'h102], 32'd3);
    check("ring_0x103", ram[13'h103], 32'd4);
    check_io("ring_wptr", 3'd3, 32'd2);
    check("model_wptr", m_wptr, 2);

    // CPU writes hold off a pending sample for three cycles
    io_write(3'd0, 32'd0);
    io_write(3'd0, 32'd1);
    bus.smp_valid = 1; bus.smp_data = 32'hAA;
    tick();
    bus.smp_valid = 0;
    bus.cpu_wr = 1; bus.cpu_addr = 16'h020; bus.cpu_dout = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("cpu_prio_we", bus.ram_we, 1'b1);
      check("cpu_prio_addr", bus.ram_addr, 13'h020);
      tick();
    end
    bus.cpu_wr = 0;
    #1;
    check("late_we", bus.ram_we, 1'b1);
    check("late_addr", bus.ram_addr, 13'h100);
    check("late_data", bus.ram_wdata, 32'hAA);
    repeat (2) tick();
    check("ram_0x100_aa", ram[13'h100], 32'hAA);
    check("ram_0x020_55", ram[13'h020], 32'h55);

    // Continuous cpu_rd: FIFO fills at 4, then stalls and overflow counts
    io_write(3'd0, 32'd3);
    bus.cpu_rd = 1; bus.cpu_addr = 16'h040;
    for (int i = 0; i < 4; i++) begin
      bus.smp_valid = 1; bus.smp_data = WIDTH'(32'h10 + i);
      #1;
      check("fill_ready", bus.smp_ready, 1'b1);
      tick();
    end
    bus.smp_data = 32'h14;
    #1;
    check("full_ready", bus.smp_ready, 1'b0);
    repeat (3) tick();
    bus.smp_valid = 0;
`ifdef J1_ARB_OVF_COUNT_EN
    ovf_exp = 3;
`else
    ovf_exp = 0;
`endif
    check_io("ovf_count", 3'd4, WIDTH'(ovf_exp));
    bus.cpu_rd = 0;
    repeat (6) tick();
    check("full_first", ram[13'h101], 32'h10);
    check("full_last", ram[13'h100], 32'h13);

    // Disable with two buffered samples, then re-enable
    bus.cpu_rd = 1;
    for (int i = 0; i < 2; i++) begin
      bus.smp_valid = 1; bus.smp_data = WIDTH'(32'h21 + i);
      tick();
    end
    bus.smp_valid = 0;
    io_write(3'd0, 32'd0);
    bus.cpu_rd = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("flush_no_we", bus.ram_we, 1'b0);
      tick();
    end
    io_write(3'd0, 32'd1);
    check_io("reen_wptr", 3'd3, 32'd0);
    bus.smp_valid = 1; bus.smp_data = 32'h77;
    tick();
    bus.smp_valid = 0;
    repeat (2) tick();
    check("reen_base", ram[13'h100], 32'h77);

    // LEN=0 blocks acceptance
    io_write(3'd2, 32'd0);
    bus.smp_valid = 1; bus.smp_data = 32'h99;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("len0_ready", bus.smp_ready, 1'b0);
      check("len0_we", bus.ram_we, 1'b0);
      tick();
    end
    bus.smp_valid = 0;
    io_write(3'd2, 32'd4);

    // Reset with three samples buffered
    bus.cpu_rd = 1;
    for (int i = 0; i < 3; i++) begin
      bus.smp_valid = 1; bus.smp_data = WIDTH'(32'h31 + i);
      tick();
    end
    bus.smp_valid = 0;
    reset = 1;
    for (int a = 0; a < 5; a++) check_io("rst_mid_io", 3'(a), '0);
    check("rst_mid_ready", bus.smp_ready, 1'b0);
    check("rst_mid_we", bus.ram_we, 1'b0);
    repeat (2) tick();
    bus.cpu_rd = 0;
    tick();
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("post_rst_we", bus.ram_we, 1'b0);
      tick();
    end
    for (int a = 0; a < 5; a++) check_io("post_rst_io", 3'(a), '0);

    // Randomized traffic
    io_write(3'd1, $urandom);
    io_write(3'd2, $urandom_range(1, 8));
    io_write(3'd0, 32'd1);
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      bus.cpu_rd   = (r < 15);
      bus.cpu_wr   = (r >= 15 && r < 25);
      bus.cpu_addr = 16'($urandom);
      bus.cpu_dout = $urandom;
      bus.smp_valid = 1'($urandom_range(0, 1));
      bus.smp_data  = $urandom;
      r = $urandom_range(0, 99);
      if (r < 6) begin
        bus.io_wr   = 1;
        bus.io_addr = 3'($urandom_range(0, 7));
        case (bus.io_addr)
          3'd0:    bus.io_wdata = {30'($urandom), 1'($urandom), 1'($urandom_range(0, 7) != 0)};
          3'd2:    bus.io_wdata = $urandom_range(0, 9);
          default: bus.io_wdata = $urandom;
        endcase
      end else begin
        bus.io_wr   = 0;
        bus.io_addr = 3'($urandom_range(0, 7));
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
      if (!m_en && !reset && $urandom_range(0, 3) == 0) begin
        bus.io_addr = 3'd0;
        bus.io_wdata = 32'd1;
        bus.io_wr = 1;
        if (m_len == 0) begin
          bus.io_addr = 3'd2;
          bus.io_wdata = $urandom_range(1, 8);
        end
        bus.cpu_rd = 0; bus.cpu_wr = 0;
        tick();
        bus.io_wr = 0;
      end
    end
    reset = 0;
    bus.io_wr = 0; bus.cpu_rd = 0; bus.cpu_wr = 0; bus.smp_valid = 0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
